// File: rtl/drive_polar_modulation_multi_channel.sv
// Time-multiplexed polar-to-IQ modulator: NUM_CHANNEL drive channels share one
// sin/cos LUT pair. Per sample: phase = nco + envelope + frame[ch] (virtual-Z),
// then I/Q = {cos,sin}[phase] * amp, keeping the top OUTPUT_WIDTH product bits.
// Three pipeline stages, one sample per cycle, whole pipe stalls on en=0.

// Per-channel frame-phase register (load or modular add).
module drive_polar_modulation_multi_channel_frame #(
    parameter int PHASE_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               wr_mode,
    input  logic [PHASE_W-1:0] wr_phase,
    output logic [PHASE_W-1:0] phase
);
    logic [PHASE_W-1:0] phase_q, phase_d;

    // Next frame phase: hold, load, or add with natural wrap.
    always_comb begin
        phase_d = phase_q;
        if (wr_en) phase_d = wr_mode ? (phase_q + wr_phase) : wr_phase;
    end

    // Frame register; updates are independent of the pipeline stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= '0;
        else        phase_q <= phase_d;
    end

    assign phase = phase_q;
endmodule

module drive_polar_modulation_multi_channel #(
    parameter int NUM_CHANNEL        = 4,
    parameter int CH_ID_WIDTH        = 2,
    parameter int SIN_LUT_NUM_ENTRY  = 1024,
    parameter int SIN_LUT_ADDR_WIDTH = 10,
    parameter int SIN_LUT_DATA_WIDTH = 8,
    parameter int AMP_WIDTH          = 8,
    parameter int OUTPUT_WIDTH       = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          sin_lut_wr_en,
    input  logic                          cos_lut_wr_en,
    input  logic [SIN_LUT_ADDR_WIDTH-1:0] sinusoidal_lut_wr_addr,
    input  logic [SIN_LUT_DATA_WIDTH-1:0] sinusoidal_lut_wr_data,
    input  logic                          frame_wr_en,
    input  logic                          frame_wr_mode,
    input  logic [CH_ID_WIDTH-1:0]        frame_wr_ch,
    input  logic [SIN_LUT_ADDR_WIDTH-1:0] frame_wr_phase,
    input  logic                          valid_in,
    input  logic [CH_ID_WIDTH-1:0]        ch_in,
    input  logic [SIN_LUT_ADDR_WIDTH-1:0] nco_phase,
    input  logic [SIN_LUT_ADDR_WIDTH-1:0] enve_memory_phase,
    input  logic [AMP_WIDTH-1:0]          enve_memory_amp,
    output logic [OUTPUT_WIDTH-1:0]       i_out,
    output logic [OUTPUT_WIDTH-1:0]       q_out,
    output logic [CH_ID_WIDTH-1:0]        ch_out,
    output logic                          valid_out
);
    localparam int STAGES = 3;
    localparam int PROD_W = SIN_LUT_DATA_WIDTH + AMP_WIDTH;
    localparam int SHIFT  = PROD_W - OUTPUT_WIDTH;

    // ---------------- frame phases ----------------
    logic [NUM_CHANNEL-1:0][SIN_LUT_ADDR_WIDTH-1:0] frame_phase;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_frame
        logic frame_sel;
        assign frame_sel = frame_wr_en && (frame_wr_ch == CH_ID_WIDTH'(g));
        drive_polar_modulation_multi_channel_frame #(
            .PHASE_W (SIN_LUT_ADDR_WIDTH)
        ) u_frame (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (frame_sel),
            .wr_mode  (frame_wr_mode),
            .wr_phase (frame_wr_phase),
            .phase    (frame_phase[g])
        );
    end

    // ---------------- shared LUTs ----------------
    logic signed [SIN_LUT_DATA_WIDTH-1:0] sin_lut [SIN_LUT_NUM_ENTRY];
    logic signed [SIN_LUT_DATA_WIDTH-1:0] cos_lut [SIN_LUT_NUM_ENTRY];

    // LUT writes (not reset, not stalled); same-edge readers see old data.
    always_ff @(posedge clk) begin
        if (sin_lut_wr_en) sin_lut[sinusoidal_lut_wr_addr] <= sinusoidal_lut_wr_data;
        if (cos_lut_wr_en) cos_lut[sinusoidal_lut_wr_addr] <= sinusoidal_lut_wr_data;
    end

    // ---------------- pipeline ----------------
    logic [STAGES:1]                      vld_pipe_q, vld_pipe_d;
    logic [SIN_LUT_ADDR_WIDTH-1:0]        s1_addr_q, s1_addr_d;
    logic [AMP_WIDTH-1:0]                 s1_amp_q, s1_amp_d, s2_amp_q, s2_amp_d;
    logic [CH_ID_WIDTH-1:0]               s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d, s3_ch_q, s3_ch_d;
    logic signed [SIN_LUT_DATA_WIDTH-1:0] s2_cos_q, s2_cos_d, s2_sin_q, s2_sin_d;
    logic [OUTPUT_WIDTH-1:0]              s3_i_q, s3_i_d, s3_q_q, s3_q_d;
    logic signed [PROD_W-1:0]             cos_ext, sin_ext, amp_ext, i_prod, q_prod;

    // Stage next-values: phase sum, LUT read, scale-and-truncate.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], valid_in};
        // S1: frame read uses the pre-update value on a same-cycle frame write
        s1_addr_d  = nco_phase + enve_memory_phase + frame_phase[ch_in];
        s1_amp_d   = enve_memory_amp;
        s1_ch_d    = ch_in;
        // S2
        s2_cos_d   = cos_lut[s1_addr_q];
        s2_sin_d   = sin_lut[s1_addr_q];
        s2_amp_d   = s1_amp_q;
        s2_ch_d    = s1_ch_q;
        // S3: signed LUT x zero-extended amp; product fits PROD_W exactly
        cos_ext    = PROD_W'(s2_cos_q);
        sin_ext    = PROD_W'(s2_sin_q);
        amp_ext    = PROD_W'(s2_amp_q);
        i_prod     = cos_ext * amp_ext;
        q_prod     = sin_ext * amp_ext;
        s3_i_d     = OUTPUT_WIDTH'(i_prod >>> SHIFT);
        s3_q_d     = OUTPUT_WIDTH'(q_prod >>> SHIFT);
        s3_ch_d    = s2_ch_q;
    end

    // Pipeline registers: all advance together on en, all hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_addr_q  <= '0;
            s1_amp_q   <= '0;
            s1_ch_q    <= '0;
            s2_cos_q   <= '0;
            s2_sin_q   <= '0;
            s2_amp_q   <= '0;
            s2_ch_q    <= '0;
            s3_i_q     <= '0;
            s3_q_q     <= '0;
            s3_ch_q    <= '0;
        end else if (en) begin
            vld_pipe_q <= vld_pipe_d;
            s1_addr_q  <= s1_addr_d;
            s1_amp_q   <= s1_amp_d;
            s1_ch_q    <= s1_ch_d;
            s2_cos_q   <= s2_cos_d;
            s2_sin_q   <= s2_sin_d;
            s2_amp_q   <= s2_amp_d;
            s2_ch_q    <= s2_ch_d;
            s3_i_q     <= s3_i_d;
            s3_q_q     <= s3_q_d;
            s3_ch_q    <= s3_ch_d;
        end
    end

    assign i_out     = s3_i_q;
    assign q_out     = s3_q_q;
    assign ch_out    = s3_ch_q;
    assign valid_out = vld_pipe_q[STAGES];
endmodule
